// File: rtl/filter_spad_ctrl.sv
// Filter scratchpad sequencer: fills the spad from the weight FIFO, then replays
// read addresses in (window, s, c, f) order under MAC back-pressure.
module filter_spad_ctrl #(
  parameter int MEM_DEPTH  = 224,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] cfg_s,
  input  logic [ADDR_WIDTH-1:0] cfg_c,
  input  logic [ADDR_WIDTH-1:0] cfg_f,
  input  logic [CNT_WIDTH-1:0]  cfg_win,
  input  logic                  fil_valid,
  output logic                  fil_ready,
  output logic                  spad_clr,
  output logic                  spad_w_en,
  input  logic                  spad_full,
  output logic                  spad_r_en,
  output logic [ADDR_WIDTH-1:0] spad_r_addr,
  input  logic                  mac_ready,
  output logic                  mac_valid,
  output logic                  mac_last,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
);

  localparam int PROD_W = 3 * ADDR_WIDTH;
  localparam int LW     = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t                state_q, state_d;
  logic [PROD_W-1:0]     n_full;
  logic                  cfg_ok;
  logic                  accept;
  logic [LW-1:0]         n_q;
  logic [LW-1:0]         ld_cnt_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [CNT_WIDTH-1:0]  win_q;
  logic [CNT_WIDTH-1:0]  w_q;
  logic                  clr_q;
  logic                  err_q;
  logic                  vld_p1;
  logic                  last_p1;
  logic                  loading;
  logic                  load_last;
  logic                  idx_last;
  logic                  win_last;
  logic                  overfill;

  // Shape product kept at full width so an oversized S*C*F cannot alias into range.
  always_comb begin
    n_full = PROD_W'(cfg_s) * PROD_W'(cfg_c) * PROD_W'(cfg_f);
    cfg_ok = (cfg_s != '0) && (cfg_c != '0) && (cfg_f != '0) && (cfg_win != '0) &&
             (n_full <= PROD_W'(MEM_DEPTH));
    accept = (state_q == IDLE) && start && cfg_ok;
  end

  // With f innermost, (s*C + c)*F + f is simply the linear issue index in a window.
  assign loading     = (state_q == LOAD) && (ld_cnt_q < n_q);
  assign load_last   = (ld_cnt_q == n_q - LW'(1));
  assign idx_last    = ({1'b0, idx_q} == n_q - LW'(1));
  assign win_last    = (w_q == win_q - CNT_WIDTH'(1));
  assign overfill    = loading && spad_full;

  assign fil_ready   = loading;
  assign spad_w_en   = fil_valid && loading && !spad_full;
  assign spad_r_en   = (state_q == RUN) && mac_ready;
  assign spad_r_addr = idx_q;
  assign spad_clr    = clr_q;
  assign mac_valid   = vld_p1;
  assign mac_last    = last_p1;
  assign busy        = (state_q == LOAD) || (state_q == RUN);
  assign done        = (state_q == DONE);
  assign cfg_err     = err_q;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = LOAD;
      LOAD: begin
        if (overfill)                    state_d = IDLE;
        else if (spad_w_en && load_last) state_d = RUN;
      end
      RUN:  if (spad_r_en && idx_last && win_last) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      n_q      <= '0;
      win_q    <= '0;
      ld_cnt_q <= '0;
      idx_q    <= '0;
      w_q      <= '0;
      clr_q    <= 1'b0;
      err_q    <= 1'b0;
      vld_p1   <= 1'b0;
      last_p1  <= 1'b0;
    end else begin
      clr_q <= accept;
      // p1: spad read data appears one cycle after issue
      vld_p1  <= spad_r_en;
      last_p1 <= spad_r_en && idx_last;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              n_q      <= n_full[LW-1:0];
              win_q    <= cfg_win;
              ld_cnt_q <= '0;
              idx_q    <= '0;
              w_q      <= '0;
              err_q    <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (overfill)       err_q    <= 1'b1;
          else if (spad_w_en) ld_cnt_q <= ld_cnt_q + LW'(1);
        end
        RUN: begin
          if (spad_r_en) begin
            if (idx_last) begin
              idx_q <= '0;
              w_q   <= win_last ? '0 : w_q + CNT_WIDTH'(1);
            end else begin
              idx_q <= idx_q + ADDR_WIDTH'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_filter_spad_ctrl.sv
// Self-checking bench for filter_spad_ctrl: config table, directed corner cases and
// randomized jobs checked cycle by cycle against a phase/count reference model.
module tb_filter_spad_ctrl;

  localparam int MEM_DEPTH  = 224;
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH);
  localparam int CNT_WIDTH  = 8;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  start = 1'b0;
  logic [ADDR_WIDTH-1:0] cfg_s = '0, cfg_c = '0, cfg_f = '0;
  logic [CNT_WIDTH-1:0]  cfg_win = '0;
  logic                  fil_valid = 1'b0, spad_full = 1'b0, mac_ready = 1'b0;
  logic                  fil_ready, spad_clr, spad_w_en, spad_r_en;
  logic [ADDR_WIDTH-1:0] spad_r_addr;
  logic                  mac_valid, mac_last, busy, done, cfg_err;

  int vecs = 0;
  int errs = 0;

  filter_spad_ctrl #(.MEM_DEPTH(MEM_DEPTH), .ADDR_WIDTH(ADDR_WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_s(cfg_s), .cfg_c(cfg_c), .cfg_f(cfg_f), .cfg_win(cfg_win),
    .fil_valid(fil_valid), .fil_ready(fil_ready), .spad_clr(spad_clr),
    .spad_w_en(spad_w_en), .spad_full(spad_full), .spad_r_en(spad_r_en),
    .spad_r_addr(spad_r_addr), .mac_ready(mac_ready), .mac_valid(mac_valid),
    .mac_last(mac_last), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] outs();
    return {spad_clr, busy, fil_ready, spad_w_en, spad_r_en, mac_valid, mac_last, done, cfg_err};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // After an accepted start: model the job as LOAD (count writes to N), RUN (issue
  // N*W addresses from nested loops), one DONE cycle, then IDLE.
  task automatic run_job(input int s, input int c, input int f, input int w,
                         input int mode, input bit start_in_load,
                         input int abort_at, input bit start_at_done);
    int n, phase, writes, issued, cyc, budget;
    bit fv, mr, pi, pl, first, rst_now, npi, npl;
    int q[$];
    logic [8:0] exp;
    n = s * c * f;
    for (int wi = 0; wi < w; wi++)
      for (int si = 0; si < s; si++)
        for (int ci = 0; ci < c; ci++)
          for (int fi = 0; fi < f; fi++)
            q.push_back((si * c + ci) * f + fi);
    @(negedge clk);
    cfg_s = ADDR_WIDTH'(s); cfg_c = ADDR_WIDTH'(c); cfg_f = ADDR_WIDTH'(f);
    cfg_win = CNT_WIDTH'(w); start = 1'b1;
    #1 chk("idle_before_start", busy, 0);
    phase = 0; writes = 0; issued = 0; cyc = 0; pi = 0; pl = 0; first = 1; rst_now = 0;
    budget = n * w * 8 + n * 4 + 20;
    while (1) begin
      @(negedge clk);
      start = 1'b0;
      case (mode)
        0: begin fv = 1; mr = 1; end
        1: begin fv = (cyc % 2 == 0); mr = (cyc % 3 != 2); end
        default: begin fv = 1'($urandom_range(0, 1)); mr = ($urandom_range(0, 3) != 0); end
      endcase
      fil_valid = fv; mac_ready = mr;
      if (start_in_load && phase == 0 && writes == 2) begin
        start = 1'b1; cfg_s = 1; cfg_c = 1; cfg_f = 1; cfg_win = 1;
      end
      if (start_at_done && phase == 2) start = 1'b1;
      rst_now = (abort_at > 0) && (phase == 1) && (issued == abort_at);
      reset = !rst_now;
      #1;
      exp = {first, (phase <= 1), (phase == 0), (phase == 0) && fv, (phase == 1) && mr,
             pi, pl, (phase == 2), 1'b0};
      chk("outs", outs(), exp);
      if (phase == 1 && mr) chk("addr", spad_r_addr, q[issued]);
      npi = 0; npl = 0;
      if (phase == 0 && fv) begin
        writes++;
        if (writes == n) phase = 1;
      end else if (phase == 1 && mr) begin
        npi = 1; npl = (issued % n == n - 1);
        issued++;
        if (issued == n * w) phase = 2;
      end else if (phase == 2) begin
        phase = 3;
      end
      pi = npi; pl = npl; first = 0;
      if (rst_now || phase == 3) break;
      cyc++;
      if (cyc > budget) begin
        chk("job_timeout", phase, 3);
        break;
      end
    end
    // Next cycle the block must be idle with all outputs low (after done, reset or ignored start).
    @(negedge clk);
    reset = 1'b1; start = 1'b0; fil_valid = 1'b0; mac_ready = 1'b0;
    #1;
    chk("post_idle", outs(), 0);
    chk("post_addr", spad_r_addr, 0);
  endtask

  typedef struct {
    int s, c, f, w;
    bit legal;
    int mode;
    bit sil;
    int abort_at;
    bit sad;
  } cfg_vec_t;

  cfg_vec_t tbl[11];

  initial begin
    tbl[0]  = '{3, 2, 2, 2, 1'b1, 0, 1'b0, 0, 1'b0};
    tbl[1]  = '{3, 2, 0, 2, 1'b0, 0, 1'b0, 0, 1'b0};
    tbl[2]  = '{15, 4, 4, 1, 1'b0, 0, 1'b0, 0, 1'b0};
    tbl[3]  = '{3, 2, 2, 2, 1'b1, 1, 1'b1, 0, 1'b0};
    tbl[4]  = '{0, 1, 1, 1, 1'b0, 0, 1'b0, 0, 1'b0};
    tbl[5]  = '{1, 1, 1, 0, 1'b0, 0, 1'b0, 0, 1'b0};
    tbl[6]  = '{15, 15, 1, 1, 1'b0, 0, 1'b0, 0, 1'b0};
    tbl[7]  = '{16, 16, 1, 1, 1'b0, 0, 1'b0, 0, 1'b0};
    tbl[8]  = '{14, 4, 4, 1, 1'b1, 0, 1'b0, 0, 1'b0};
    tbl[9]  = '{3, 2, 2, 2, 1'b1, 0, 1'b0, 5, 1'b0};
    tbl[10] = '{3, 2, 2, 2, 1'b1, 2, 1'b0, 0, 1'b1};

    repeat (3) @(negedge clk);
    #1 chk("reset_outs", outs(), 0);
    chk("reset_addr", spad_r_addr, 0);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("idle_outs", outs(), 0);

    for (int i = 0; i < 11; i++) begin
      if (tbl[i].legal) begin
        run_job(tbl[i].s, tbl[i].c, tbl[i].f, tbl[i].w, tbl[i].mode,
                tbl[i].sil, tbl[i].abort_at, tbl[i].sad);
      end else begin
        @(negedge clk);
        cfg_s = ADDR_WIDTH'(tbl[i].s); cfg_c = ADDR_WIDTH'(tbl[i].c);
        cfg_f = ADDR_WIDTH'(tbl[i].f); cfg_win = CNT_WIDTH'(tbl[i].w); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("illegal_err", cfg_err, 1);
        chk("illegal_idle", {spad_clr, busy, fil_ready}, 0);
      end
    end

    // Over-fill guard: spad_full during LOAD aborts with cfg_err and no done.
    @(negedge clk);
    cfg_s = 2; cfg_c = 2; cfg_f = 2; cfg_win = 1; start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start = 1'b0; fil_valid = 1'b1;
    end
    @(negedge clk);
    fil_valid = 1'b0; spad_full = 1'b1;
    #1 chk("overfill_loading", {busy, fil_ready}, 2'b11);
    @(negedge clk);
    spad_full = 1'b0;
    #1 chk("overfill_abort", {busy, done, fil_ready, cfg_err}, 4'b0001);

    for (int j = 0; j < 8; j++)
      run_job(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)),
              int'($urandom_range(1, 4)), int'($urandom_range(1, 3)), 2, 1'b0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/filter_spad_ctrl.md
Name: filter_spad_ctrl

Overview:
- Sequencer for one PE's filter scratchpad.
- On a start command it latches a filter-block shape, clears the spad write pointer and fills the spad from an upstream valid/ready stream.
- It then replays read addresses in (window, s, c, f) loop order, with back-pressure from the MAC stage.
- Sits between the PE config/filter FIFO and the filter spad plus MAC datapath.

Parameters:
MEM_DEPTH, 224, spad capacity in words.
ADDR_WIDTH, $clog2(MEM_DEPTH), spad address width.
CNT_WIDTH, 8, width of the window counter.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-low reset.
start  input  1  one-cycle command; accepted only in IDLE.
cfg_s  input  ADDR_WIDTH  filter row width S.
cfg_c  input  ADDR_WIDTH  channels per pass C.
cfg_f  input  ADDR_WIDTH  filters per pass F.
cfg_win  input  CNT_WIDTH  output windows W (replay count).
fil_valid  input  1  upstream weight available.
fil_ready  output  1  controller accepts a weight.
spad_clr  output  1  one-cycle clear to spad write pointer (active-high).
spad_w_en  output  1  spad write enable.
spad_full  input  1  spad full flag.
spad_r_en  output  1  spad read enable.
spad_r_addr  output  ADDR_WIDTH  spad read address.
mac_ready  input  1  MAC can take an operand next cycle.
mac_valid  output  1  spad dout valid for MAC this cycle.
mac_last  output  1  accompanies the final operand of a window.
busy  output  1  high in LOAD/RUN.
done  output  1  one-cycle pulse on completion.
cfg_err  output  1  sticky illegal-config flag; cleared by the next accepted legal start.

Behaviour:
- Reset (reset==0 at a rising edge): state IDLE.
  - All outputs 0 and spad_r_addr 0.
  - Counters and latched config 0.
  - Overrides any state, including mid-LOAD or mid-RUN.
- Config rule: N = S*C*F, computed at full precision.
  - Illegal if any of S, C, F, W is 0, or if N > MEM_DEPTH.
  - Illegal start: cfg_err set, spad_clr not pulsed, stay IDLE.
- IDLE:
  - start with legal config → latch cfg, pulse spad_clr, clear cfg_err, go LOAD next cycle.
  - start in any other state is ignored.
- LOAD:
  - fil_ready=1 while load count < N.
  - spad_w_en = fil_valid & fil_ready; each such cycle increments the load count.
  - After the N-th write, go RUN; fil_ready drops the same edge.
  - Over-fill guard: if spad_full is seen high with count < N, set cfg_err and go IDLE without done.
- RUN: address loop, innermost first.
  - f 0..F-1, then c 0..C-1, then s 0..S-1, then window w 0..W-1.
  - spad_r_addr = (s*C + c)*F + f.
  - spad_r_en = mac_ready; counters advance only on cycles with spad_r_en=1.
  - mac_ready=0 holds the address and suppresses r_en, so no bubble is lost.
- Read latency: exactly 1 cycle.
  - mac_valid is spad_r_en registered; mac_last is the registered "f=F-1, c=C-1, s=S-1" condition.
  - MAC must consume data whenever mac_valid=1; mac_ready only gates new issue.
- Completion:
  - After the issue with w=W-1 and last indices, go DONE.
  - DONE: waits one cycle so the final mac_valid/mac_last emerge, then pulses done and returns IDLE.
  - busy=0 in DONE.
- Wrap-around: at the end of each window the f/c/s counters return to 0 and the address restarts at 0.
- Simultaneous events:
  - start arriving in the same cycle as done is ignored.
  - A new start is accepted from the cycle after done.
- Weights are passed directly from FIFO to spad din; this block never handles data.

Test Plan:
- Normal run: S=3, C=2, F=2, W=2, fil_valid held high, mac_ready high → spad_clr one cycle after start; 12 spad_w_en pulses; then addresses 0..11 twice; mac_last on the 12th and 24th mac_valid; done pulse; 24 reads total.
- Back-pressure: same config, fil_valid toggling 1/0 and mac_ready low every 3rd cycle → still exactly 12 writes; address sequence unchanged with no skips or duplicates; mac_valid never high the cycle after mac_ready=0.
- Illegal config: start with cfg_f=0, then with S=15, C=4, F=4 (240 > 224) → cfg_err=1, no spad_clr, busy=0; next legal start clears cfg_err.
- Boundary: S=14, C=4, F=4, W=1 (N=224) → 224 writes; last address 223; done pulse.
- Reset mid-RUN: assert reset low at read #5 → next edge: all outputs 0, IDLE; a subsequent start re-pulses spad_clr and reloads.
- Start while busy: pulse start during LOAD → ignored; write count and cfg remain as latched.
